// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared state encoding and nibble width for the serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: operation request and result handshakes of the serial adder sequencer.
interface nibble_serial_adder_ctrl_if #(parameter int NIBBLES = 4);
   localparam int W = 4 * NIBBLES;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         cin;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;
   modport master (
      output start_valid, op_a, op_b, sub, cin, res_ready,
      input  start_ready, res_valid, sum, cout, ovf, busy
   );
   modport slave (
      input  start_valid, op_a, op_b, sub, cin, res_ready,
      output start_ready, res_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl_cla4_nibble.sv
// cla4_nibble: combinational 4-bit carry-lookahead adder, {c4,s} = a + b + c0.
module cla4_nibble (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       c4
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;
   assign g = a & b;
   assign p = a | b;
   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c0);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);
   assign s  = a ^ b ^ c[3:0];
   assign c4 = c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: multi-nibble add/subtract sequencer time-sharing one CLA nibble adder,
// LSB nibble first, carry rippled between cycles through a register.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input logic                        clk,
   input logic                        rst,
   nibble_serial_adder_ctrl_if.slave  bus
);
   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic               start_ready_q, start_ready_d, res_valid_q, res_valid_d, busy_q, busy_d;
   logic [NIBBLE_W-1:0] nib_a, nib_b, s4;
   logic               c4, last;

   assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
   assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
   assign last  = idx_q == IDX_W'(NIBBLES - 1);

   cla4_nibble u_cla (.a(nib_a), .b(nib_b), .c0(carry_q), .s(s4), .c4(c4));

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      sum_d         = sum_q;
      idx_d         = idx_q;
      carry_d       = carry_q;
      cout_d        = cout_q;
      ovf_d         = ovf_q;
      start_ready_d = start_ready_q;
      res_valid_d   = res_valid_q;
      busy_d        = busy_q;
      case (state_q)
         IDLE: if (bus.start_valid && start_ready_q) begin
            a_d           = bus.op_a;
            b_d           = bus.sub ? ~bus.op_b : bus.op_b;
            carry_d       = bus.sub ? 1'b1 : bus.cin;
            idx_d         = '0;
            state_d       = RUN;
            start_ready_d = 1'b0;
            busy_d        = 1'b1;
         end
         RUN: begin
            sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = s4;
            carry_d = c4;
            idx_d   = last ? idx_q : IDX_W'(idx_q + 1'b1);
            if (last) begin
               cout_d      = c4;
               // carry into the MSB is a^b^s there; overflow when it differs from carry out
               ovf_d       = c4 ^ (a_q[W-1] ^ b_q[W-1] ^ s4[NIBBLE_W-1]);
               res_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: if (bus.res_ready) begin
            res_valid_d   = 1'b0;
            busy_d        = 1'b0;
            start_ready_d = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         sum_q         <= '0;
         idx_q         <= '0;
         carry_q       <= 1'b0;
         cout_q        <= 1'b0;
         ovf_q         <= 1'b0;
         start_ready_q <= 1'b1;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         sum_q         <= sum_d;
         idx_q         <= idx_d;
         carry_q       <= carry_d;
         cout_q        <= cout_d;
         ovf_q         <= ovf_d;
         start_ready_q <= start_ready_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.start_ready = start_ready_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.sum         = sum_q;
   assign bus.cout        = cout_q;
   assign bus.ovf         = ovf_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed vectors with hand-computed results for the serial adder sequencer.
module tb_nibble_serial_adder_ctrl;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();
   nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ci,
                         input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
      int cnt = 0;
      while (!bus.start_ready && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({tag, " start_ready"}, 32'(bus.start_ready), 1);
      bus.op_a = a;
      bus.op_b = b;
      bus.sub = s;
      bus.cin = ci;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      bus.op_a = ~a;
      bus.op_b = ~b;
      cnt = 0;
      while (!bus.res_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      chk({tag, " latency"}, 32'(cnt), N);
      chk({tag, " sum"}, 32'(bus.sum), 32'(e_sum));
      chk({tag, " cout"}, 32'(bus.cout), 32'(e_cout));
      chk({tag, " ovf"}, 32'(bus.ovf), 32'(e_ovf));
      chk({tag, " busy"}, 32'(bus.busy), 1);
      if (bus.res_ready) begin
         tick();
         chk({tag, " res_valid drop"}, 32'(bus.res_valid), 0);
         chk({tag, " start_ready back"}, 32'(bus.start_ready), 1);
      end
   endtask

   initial begin
      int cnt;
      bus.start_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst start_ready", 32'(bus.start_ready), 1);
      chk("rst res_valid", 32'(bus.res_valid), 0);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst sum", 32'(bus.sum), 0);
      chk("rst cout", 32'(bus.cout), 0);
      chk("rst ovf", 32'(bus.ovf), 0);

      run_op("add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
      run_op("add_cout", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("add_cin", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub_neg", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_cin0", 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
      run_op("b2b_0", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op("b2b_1", 16'h1000, 16'h1000, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0);

      // backpressure: result must hold while the consumer stalls, restarts are ignored
      bus.res_ready = 1'b0;
      bus.op_a = 16'h0102;
      bus.op_b = 16'h0304;
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      bus.start_valid = 1'b1;
      tick();
      bus.op_a = 16'hAAAA;
      bus.op_b = 16'h5555;
      chk("bp start_ready run", 32'(bus.start_ready), 0);
      cnt = 0;
      while (!bus.res_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("bp latency", 32'(cnt), N);
      for (int i = 0; i < 5; i++) begin
         chk("bp hold valid", 32'(bus.res_valid), 1);
         chk("bp hold sum", 32'(bus.sum), 32'h0406);
         chk("bp hold cout", 32'(bus.cout), 0);
         chk("bp hold ovf", 32'(bus.ovf), 0);
         chk("bp start_ready done", 32'(bus.start_ready), 0);
         tick();
      end
      bus.start_valid = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      chk("bp release valid", 32'(bus.res_valid), 0);
      chk("bp release start_ready", 32'(bus.start_ready), 1);
      chk("bp release busy", 32'(bus.busy), 0);

      // reset during the second RUN cycle aborts the operation
      bus.op_a = 16'h4321;
      bus.op_b = 16'h1111;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      tick();
      chk("mid busy", 32'(bus.busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid rst res_valid", 32'(bus.res_valid), 0);
      chk("mid rst sum", 32'(bus.sum), 0);
      chk("mid rst start_ready", 32'(bus.start_ready), 1);
      chk("mid rst busy", 32'(bus.busy), 0);
      run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
